// File: rtl/dfr_pkg.sv
// Shared types for the DFR run sequencer, reservoir datapath and readout.
package dfr_pkg;

  // Run phase as seen by the datapath and readout blocks.
  typedef enum logic [1:0] {
    PHASE_IDLE  = 2'd0,
    PHASE_INIT  = 2'd1,
    PHASE_TRAIN = 2'd2,
    PHASE_TEST  = 2'd3
  } phase_t;

  // Sequencer FSM states.
  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_LOAD = 3'd1,
    S_STEP = 3'd2,
    S_NEXT = 3'd3,
    S_DONE = 3'd4
  } state_t;

  // First phase after cur whose sample count is nonzero; PHASE_IDLE if none is left.
  function automatic phase_t next_phase(input phase_t cur, input logic init_nz,
                                        input logic train_nz, input logic test_nz);
    phase_t np;
    np = PHASE_IDLE;
    case (cur)
      PHASE_IDLE: begin
        if (init_nz)       np = PHASE_INIT;
        else if (train_nz) np = PHASE_TRAIN;
        else if (test_nz)  np = PHASE_TEST;
      end
      PHASE_INIT: begin
        if (train_nz)      np = PHASE_TRAIN;
        else if (test_nz)  np = PHASE_TEST;
      end
      PHASE_TRAIN: begin
        if (test_nz)       np = PHASE_TEST;
      end
      default:             np = PHASE_IDLE;
    endcase
    return np;
  endfunction

endpackage

// File: rtl/dfr_sequencer_if.sv
// Sequencer <-> reservoir datapath signals.
// Handshake: step_req rises when a step is issued and stays high until the cycle in
// which step_ack is also high; that cycle completes the step. step_ack while step_req
// is low has no effect. sample_load is a single-cycle strobe qualified by
// sample_mem_addr in the same cycle. capture_en marks steps whose state is recorded.
interface dfr_sequencer_if #(
  parameter int ADDR_W = 16
);
  logic              sample_load;
  logic [ADDR_W-1:0] sample_mem_addr;
  logic              step_req;
  logic              step_ack;
  logic              capture_en;

  modport master (
    output sample_load, sample_mem_addr, step_req, capture_en,
    input  step_ack
  );

  modport slave (
    input  sample_load, sample_mem_addr, step_req, capture_en,
    output step_ack
  );
endinterface

// File: rtl/dfr_nested_counter.sv
// Step-within-sample / sample-within-phase counter pair with captured limits.
module dfr_nested_counter #(
  parameter int CNT_W = 32
) (
  input  logic             S_AXI_ACLK,
  input  logic             S_AXI_ARESETN,
  input  logic             clear,
  input  logic             set_steps,
  input  logic [CNT_W-1:0] steps_in,
  input  logic             start_phase,
  input  logic [CNT_W-1:0] samples_in,
  input  logic             inc_step,
  input  logic             inc_sample,
  output logic [CNT_W-1:0] step_idx,
  output logic [CNT_W-1:0] sample_idx,
  output logic             last_step,
  output logic             last_sample
);
  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

  logic [CNT_W-1:0] step_lim_q;
  logic [CNT_W-1:0] sample_lim_q;

  // Limits: steps captured once per run (0 means 1), samples once per phase.
  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      step_lim_q   <= '0;
      sample_lim_q <= '0;
    end else if (clear) begin
      step_lim_q   <= '0;
      sample_lim_q <= '0;
    end else begin
      if (set_steps)   step_lim_q   <= (steps_in == '0) ? ONE : steps_in;
      if (start_phase) sample_lim_q <= samples_in;
    end
  end

  // Index counters: a new sample restarts the step index, a new phase restarts both.
  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      step_idx   <= '0;
      sample_idx <= '0;
    end else if (clear || start_phase) begin
      step_idx   <= '0;
      sample_idx <= '0;
    end else if (inc_sample) begin
      step_idx   <= '0;
      sample_idx <= sample_idx + ONE;
    end else if (inc_step) begin
      step_idx   <= step_idx + ONE;
    end
  end

  // idx < lim always holds while counting, so idx + 1 cannot wrap.
  assign last_step   = (step_idx + ONE) >= step_lim_q;
  assign last_sample = (sample_idx + ONE) >= sample_lim_q;

endmodule

// File: rtl/dfr_sequencer.sv
// Sequences one DFR run through INIT, TRAIN and TEST phases of sample loads and steps.
module dfr_sequencer
  import dfr_pkg::*;
#(
  parameter int ADDR_W = 16,
  parameter int CNT_W  = 32
) (
  input  logic               S_AXI_ACLK,
  input  logic               S_AXI_ARESETN,
  input  logic               start,
  input  logic               abort,
  input  logic [CNT_W-1:0]   num_init_samples,
  input  logic [CNT_W-1:0]   num_train_samples,
  input  logic [CNT_W-1:0]   num_test_samples,
  input  logic [CNT_W-1:0]   num_steps_per_sample,
  output logic               busy,
  output logic               done,
  output phase_t             phase,
  output logic [CNT_W-1:0]   sample_idx,
  output logic [CNT_W-1:0]   step_idx,
  output state_t             state_dbg,
  dfr_sequencer_if.master    dp
);
  state_t            state_q, state_d;
  phase_t            phase_q, phase_d;
  logic [ADDR_W-1:0] addr_q;
  logic [CNT_W-1:0]  init_q, train_q, test_q;
  logic [CNT_W-1:0]  c_init, c_train, c_test, np_cnt;
  phase_t            np;
  logic              latch, clr, set_steps, start_phase, inc_step, inc_sample;
  logic              addr_clr, addr_inc, last_step, last_sample;

  dfr_nested_counter #(.CNT_W(CNT_W)) u_cnt (
    .S_AXI_ACLK    (S_AXI_ACLK),
    .S_AXI_ARESETN (S_AXI_ARESETN),
    .clear         (clr),
    .set_steps     (set_steps),
    .steps_in      (num_steps_per_sample),
    .start_phase   (start_phase),
    .samples_in    (np_cnt),
    .inc_step      (inc_step),
    .inc_sample    (inc_sample),
    .step_idx      (step_idx),
    .sample_idx    (sample_idx),
    .last_step     (last_step),
    .last_sample   (last_sample)
  );

  // Phase lookahead: live inputs while idle, captured counts once running.
  always_comb begin
    c_init  = (state_q == S_IDLE) ? num_init_samples  : init_q;
    c_train = (state_q == S_IDLE) ? num_train_samples : train_q;
    c_test  = (state_q == S_IDLE) ? num_test_samples  : test_q;
    np      = next_phase((state_q == S_IDLE) ? PHASE_IDLE : phase_q,
                         c_init != '0, c_train != '0, c_test != '0);
    case (np)
      PHASE_INIT:  np_cnt = c_init;
      PHASE_TRAIN: np_cnt = c_train;
      PHASE_TEST:  np_cnt = c_test;
      default:     np_cnt = '0;
    endcase
  end

  // Next-state and control decode; abort outranks everything outside IDLE.
  always_comb begin
    state_d     = state_q;
    phase_d     = phase_q;
    latch       = 1'b0;
    clr         = 1'b0;
    set_steps   = 1'b0;
    start_phase = 1'b0;
    inc_step    = 1'b0;
    inc_sample  = 1'b0;
    addr_clr    = 1'b0;
    addr_inc    = 1'b0;
    if (state_q != S_IDLE && abort) begin
      state_d  = S_IDLE;
      phase_d  = PHASE_IDLE;
      clr      = 1'b1;
      addr_clr = 1'b1;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start && !abort) begin
            latch     = 1'b1;
            set_steps = 1'b1;
            addr_clr  = 1'b1;
            if (np == PHASE_IDLE) begin
              state_d = S_DONE;
            end else begin
              phase_d     = np;
              start_phase = 1'b1;
              state_d     = S_LOAD;
            end
          end
        end
        S_LOAD: state_d = S_STEP;
        S_STEP: if (dp.step_ack) state_d = S_NEXT;
        S_NEXT: begin
          if (!last_step) begin
            inc_step = 1'b1;
            state_d  = S_STEP;
          end else if (!last_sample) begin
            inc_sample = 1'b1;
            addr_inc   = 1'b1;
            state_d    = S_LOAD;
          end else if (np != PHASE_IDLE) begin
            phase_d     = np;
            start_phase = 1'b1;
            addr_inc    = 1'b1;
            state_d     = S_LOAD;
          end else begin
            phase_d  = PHASE_IDLE;
            clr      = 1'b1;
            addr_clr = 1'b1;
            state_d  = S_DONE;
          end
        end
        S_DONE: begin
          clr      = 1'b1;
          addr_clr = 1'b1;
          state_d  = S_IDLE;
        end
        default: begin
          phase_d = PHASE_IDLE;
          clr     = 1'b1;
          state_d = S_IDLE;
        end
      endcase
    end
  end

  // State, phase, global sample address and captured phase counts.
  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      state_q <= S_IDLE;
      phase_q <= PHASE_IDLE;
      addr_q  <= '0;
      init_q  <= '0;
      train_q <= '0;
      test_q  <= '0;
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
      if (addr_clr)      addr_q <= '0;
      else if (addr_inc) addr_q <= addr_q + 1'b1;
      if (latch) begin
        init_q  <= num_init_samples;
        train_q <= num_train_samples;
        test_q  <= num_test_samples;
      end
    end
  end

  assign busy               = (state_q != S_IDLE);
  assign done               = (state_q == S_DONE);
  assign phase              = phase_q;
  assign state_dbg          = state_q;
  assign dp.sample_load     = (state_q == S_LOAD);
  assign dp.step_req        = (state_q == S_STEP);
  assign dp.sample_mem_addr = addr_q;
  assign dp.capture_en      = (state_q == S_STEP) &&
                              (phase_q == PHASE_TRAIN || phase_q == PHASE_TEST);

endmodule

// File: tb/tb_dfr_sequencer.sv
// Directed bench for dfr_sequencer: full runs, phase skipping, ack timing, abort, reset.
module tb_dfr_sequencer;
  import dfr_pkg::*;

  localparam int ADDR_W = 16;
  localparam int CNT_W  = 32;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              start = 1'b0;
  logic              abort = 1'b0;
  logic [CNT_W-1:0]  n_init = '0, n_train = '0, n_test = '0, n_steps = '0;
  logic              busy, done;
  phase_t            phase;
  logic [CNT_W-1:0]  sample_idx, step_idx;
  state_t            state_dbg;

  dfr_sequencer_if #(.ADDR_W(ADDR_W)) dp_if ();

  dfr_sequencer #(.ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
    .S_AXI_ACLK           (clk),
    .S_AXI_ARESETN        (rst_n),
    .start                (start),
    .abort                (abort),
    .num_init_samples     (n_init),
    .num_train_samples    (n_train),
    .num_test_samples     (n_test),
    .num_steps_per_sample (n_steps),
    .busy                 (busy),
    .done                 (done),
    .phase                (phase),
    .sample_idx           (sample_idx),
    .step_idx             (step_idx),
    .state_dbg            (state_dbg),
    .dp                   (dp_if)
  );

  // clock
  always #5 clk = ~clk;

  // scoreboard: expected {phase, sample_mem_addr} per sample_load
  logic [ADDR_W+1:0] exp_q[$];
  int checks = 0;
  int errors = 0;

  // run observations
  int  cyc, n_load, n_step, n_cap, n_done, n_req_cyc, first_load, first_req;
  int  done_cyc, busy_at_done, req_run, cap_bad;
  bit  hold_ack = 1'b0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [ADDR_W+1:0] pa(input logic [1:0] p, input int a);
    logic [ADDR_W-1:0] a16;
    a16 = a[ADDR_W-1:0];
    return {p, a16};
  endfunction

  // One clock: drop start, then model the datapath ack for this cycle.
  task automatic clk_step();
    @(posedge clk);
    #1;
    start = 1'b0;
    if (dp_if.step_req) req_run++;
    else                req_run = 0;
    dp_if.step_ack = hold_ack || (dp_if.step_req && req_run >= 2);
  endtask

  task automatic observe();
    if (dp_if.sample_load) begin
      n_load++;
      if (first_load < 0) first_load = cyc;
      if (exp_q.size() == 0) check("load_unexpected", dp_if.sample_load, 0);
      else check("load_phase_addr", {phase, dp_if.sample_mem_addr}, exp_q.pop_front());
    end
    if (dp_if.step_req) begin
      n_req_cyc++;
      if (first_req < 0) first_req = cyc;
      if (dp_if.step_ack) begin
        n_step++;
        if (dp_if.capture_en) n_cap++;
      end
    end
    if (dp_if.capture_en !== (dp_if.step_req && (phase == PHASE_TRAIN || phase == PHASE_TEST)))
      cap_bad++;
    if (done) begin
      n_done++;
      done_cyc     = cyc;
      busy_at_done = int'(busy);
    end
  endtask

  // Pulse start, follow the run to its done pulse, then confirm return to idle.
  task automatic run(input int budget, input int inj_start);
    cyc = 0; n_load = 0; n_step = 0; n_cap = 0; n_done = 0; n_req_cyc = 0;
    first_load = -1; first_req = -1; done_cyc = -1; busy_at_done = -1;
    req_run = 0; cap_bad = 0;
    dp_if.step_ack = hold_ack;
    start = 1'b1;
    while (cyc < budget && n_done == 0) begin
      clk_step();
      cyc++;
      if (cyc == inj_start) start = 1'b1;
      observe();
    end
    if (n_done == 0) check("run_timeout", n_done, 1);
    check("loads_left", exp_q.size(), 0);
    exp_q.delete();
    check("capture_rule", cap_bad, 0);
    clk_step();
    check("post_busy", busy, 0);
    check("post_done", done, 0);
    check("post_state", state_dbg, S_IDLE);
    check("post_phase", phase, PHASE_IDLE);
  endtask

  initial begin
    bit hit;
    int train_steps;
    dp_if.step_ack = 1'b0;

    // reset
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", busy, 0);
    check("rst_state", state_dbg, S_IDLE);
    check("rst_load", dp_if.sample_load, 0);
    check("rst_req", dp_if.step_req, 0);
    check("rst_addr", dp_if.sample_mem_addr, 0);
    check("rst_phase", phase, PHASE_IDLE);
    rst_n = 1'b1;
    clk_step();

    // full run 2/3/1 samples, 4 steps, ack one cycle after req
    n_init = 2; n_train = 3; n_test = 1; n_steps = 4; hold_ack = 1'b0;
    exp_q = '{pa(1, 0), pa(1, 1), pa(2, 2), pa(2, 3), pa(2, 4), pa(3, 5)};
    run(300, -1);
    check("t1_loads", n_load, 6);
    check("t1_steps", n_step, 24);
    check("t1_req_cycles", n_req_cyc, 48);
    check("t1_capture", n_cap, 16);
    check("t1_first_load", first_load, 1);
    check("t1_first_req", first_req, 2);
    check("t1_done_busy", busy_at_done, 1);

    // INIT/TRAIN skipped, steps=0 acts as 1
    n_init = 0; n_train = 0; n_test = 2; n_steps = 0;
    exp_q = '{pa(3, 0), pa(3, 1)};
    run(100, -1);
    check("t2_loads", n_load, 2);
    check("t2_steps", n_step, 2);
    check("t2_capture", n_cap, 2);

    // all counts zero: straight to DONE
    n_init = 0; n_train = 0; n_test = 0; n_steps = 5;
    run(20, -1);
    check("t3_done_cyc", done_cyc, 1);
    check("t3_done_busy", busy_at_done, 1);
    check("t3_loads", n_load, 0);
    check("t3_reqs", n_req_cyc, 0);

    // ack held high: one req cycle per step, 2-cycle step period
    n_init = 1; n_train = 0; n_test = 0; n_steps = 3; hold_ack = 1'b1;
    exp_q = '{pa(1, 0)};
    run(50, -1);
    check("t4_first_req", first_req, 2);
    check("t4_req_cycles", n_req_cyc, 3);
    check("t4_steps", n_step, 3);
    check("t4_done_cyc", done_cyc, 8);
    check("t4_capture", n_cap, 0);
    hold_ack = 1'b0;
    dp_if.step_ack = 1'b0;

    // abort during the 3rd TRAIN step, with a coincident ack
    n_init = 1; n_train = 3; n_test = 1; n_steps = 2;
    req_run = 0; hit = 1'b0; train_steps = 0;
    start = 1'b1;
    for (int i = 0; i < 200 && !hit; i++) begin
      clk_step();
      if (dp_if.step_req && phase == PHASE_TRAIN) begin
        if (train_steps == 2) hit = 1'b1;
        else if (dp_if.step_ack) train_steps++;
      end
    end
    check("t5_abort_reached", hit, 1);
    check("t5_pre_addr", dp_if.sample_mem_addr, 2);
    check("t5_pre_sidx", sample_idx, 1);
    abort = 1'b1;
    dp_if.step_ack = 1'b1;
    clk_step();
    check("t5_state", state_dbg, S_IDLE);
    check("t5_busy", busy, 0);
    check("t5_done", done, 0);
    check("t5_req", dp_if.step_req, 0);
    check("t5_addr", dp_if.sample_mem_addr, 0);
    check("t5_phase", phase, PHASE_IDLE);
    check("t5_sidx", sample_idx, 0);
    check("t5_stidx", step_idx, 0);
    abort = 1'b0;
    clk_step();
    check("t5_no_done", done, 0);
    // start and abort together in IDLE: abort wins
    start = 1'b1;
    abort = 1'b1;
    clk_step();
    check("t5_sa_busy", busy, 0);
    check("t5_sa_state", state_dbg, S_IDLE);
    abort = 1'b0;
    n_init = 1; n_train = 0; n_test = 0; n_steps = 1;
    exp_q = '{pa(1, 0)};
    run(50, -1);
    check("t5_restart_loads", n_load, 1);

    // start while busy is ignored
    n_init = 2; n_train = 0; n_test = 0; n_steps = 2;
    exp_q = '{pa(1, 0), pa(1, 1)};
    run(100, 3);
    check("t6_loads", n_load, 2);
    check("t6_steps", n_step, 4);
    check("t6_done_count", n_done, 1);

    // asynchronous reset mid-run
    n_init = 3; n_train = 0; n_test = 0; n_steps = 1;
    req_run = 0;
    start = 1'b1;
    repeat (6) clk_step();
    check("t7_pre_addr", dp_if.sample_mem_addr, 1);
    check("t7_pre_req", dp_if.step_req, 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("t7_rst_busy", busy, 0);
    check("t7_rst_req", dp_if.step_req, 0);
    check("t7_rst_addr", dp_if.sample_mem_addr, 0);
    check("t7_rst_state", state_dbg, S_IDLE);
    check("t7_rst_phase", phase, PHASE_IDLE);
    #1;
    rst_n = 1'b1;
    dp_if.step_ack = 1'b0;
    clk_step();
    check("t7_idle_done", done, 0);
    n_init = 1; n_train = 1; n_test = 0; n_steps = 1;
    exp_q = '{pa(1, 0), pa(2, 1)};
    run(100, -1);
    check("t7_fresh_loads", n_load, 2);
    check("t7_fresh_first_load", first_load, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
